// File: rtl/mseq_qpsk_gen.sv
// Maximal-length sequence generator with serial-bit or QPSK-dibit output.
// Optional macro MSEQ_LOCKUP_RECOVER_EN: reseed automatically from an all-zero state.
module mseq_qpsk_gen #(
  parameter int unsigned           WIDTH    = 5,
  parameter logic [WIDTH-1:0]      TAPS_DEF = WIDTH'(5'b10010),
  parameter logic [WIDTH-1:0]      SEED_DEF = WIDTH'(5'b10101),
  parameter logic [7:0]            AMP      = 8'd100
) (
  input  logic             CLK_50MHZ,
  input  logic             RST_N,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_taps,
  input  logic [WIDTH-1:0] load_seed,
  input  logic             mode,
  output logic             out_bit,
  output logic             out_valid,
  output logic [7:0]       sym_i,
  output logic [7:0]       sym_q,
  output logic             sym_valid,
  output logic             period_pulse,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] CntMax = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [7:0]       PosAmp = AMP;
  localparam logic [7:0]       NegAmp = ~AMP + 8'd1;

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             ibit_q, ibit_d;
  logic             mode_q;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       sym_i_q, sym_i_d;
  logic [7:0]       sym_q_q, sym_q_d;
  logic             sym_valid_q, sym_valid_d;
  logic             period_q, period_d;
  logic             lockup_q, lockup_d;
  logic             fb;
  logic             phase_eff;

  always_comb begin
    fb          = ^(state_q & taps_q);
    // A mode change since last cycle discards any half-built symbol.
    phase_eff   = (mode == mode_q) ? phase_q : 1'b0;
    state_d     = state_q;
    taps_d      = taps_q;
    cnt_d       = cnt_q;
    phase_d     = mode ? phase_eff : 1'b0;
    ibit_d      = ibit_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    sym_valid_d = 1'b0;
    period_d    = 1'b0;

    if (load) begin
      taps_d  = load_taps;
      state_d = load_seed;
      cnt_d   = '0;
      phase_d = 1'b0;
    end
`ifdef MSEQ_LOCKUP_RECOVER_EN
    else if (state_q == '0) begin
      state_d = SEED_DEF;
      cnt_d   = '0;
      phase_d = 1'b0;
    end
`endif
    else if (en) begin
      state_d     = {state_q[WIDTH-2:0], fb};
      out_bit_d   = state_q[WIDTH-1];
      out_valid_d = 1'b1;
      if (cnt_q == CntMax) begin
        cnt_d    = '0;
        period_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (mode) begin
        if (!phase_eff) begin
          ibit_d  = state_q[WIDTH-1];
          phase_d = 1'b1;
        end else begin
          sym_i_d     = ibit_q ? NegAmp : PosAmp;
          sym_q_d     = state_q[WIDTH-1] ? NegAmp : PosAmp;
          sym_valid_d = 1'b1;
          phase_d     = 1'b0;
        end
      end
    end

    lockup_d = (state_d == '0);
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      state_q     <= SEED_DEF;
      taps_q      <= TAPS_DEF;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      ibit_q      <= 1'b0;
      mode_q      <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      sym_valid_q <= 1'b0;
      period_q    <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      taps_q      <= taps_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      ibit_q      <= ibit_d;
      mode_q      <= mode;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      sym_valid_q <= sym_valid_d;
      period_q    <= period_d;
      lockup_q    <= lockup_d;
    end
  end

  assign out_bit      = out_bit_q;
  assign out_valid    = out_valid_q;
  assign sym_i        = sym_i_q;
  assign sym_q        = sym_q_q;
  assign sym_valid    = sym_valid_q;
  assign period_pulse = period_q;
  assign lockup       = lockup_q;

endmodule

// File: tb/tb_mseq_qpsk_gen.sv
// Scoreboard bench for mseq_qpsk_gen with a sequence-level reference model.
module tb_mseq_qpsk_gen;

  logic       clk = 1'b0;
  logic       rst_n, en, load, mode;
  logic [4:0] load_taps, load_seed;
  logic       out_bit, out_valid, sym_valid, period_pulse, lockup;
  logic [7:0] sym_i, sym_q;

  always #10 clk = ~clk;

  mseq_qpsk_gen dut (
    .CLK_50MHZ   (clk),
    .RST_N       (rst_n),
    .en          (en),
    .load        (load),
    .load_taps   (load_taps),
    .load_seed   (load_seed),
    .mode        (mode),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .sym_i       (sym_i),
    .sym_q       (sym_q),
    .sym_valid   (sym_valid),
    .period_pulse(period_pulse),
    .lockup      (lockup)
  );

  typedef struct {
    logic       ov, sv, pp, lk, ob;
    logic [7:0] si, sq;
  } cyc_t;

  cyc_t        cq[$];
  logic        bq[$];
  logic [15:0] symq[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sequence state, pending dibit bits, shifts since restart.
  logic [4:0] m_state, m_taps;
  logic       pend[$];
  int         m_n;
  logic       m_mode_prev, m_bit;
  logic [7:0] m_si, m_sq;

  function automatic logic [7:0] amp_of(input logic b);
    return b ? 8'(256 - 100) : 8'd100;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic l, input logic m,
                     input logic [4:0] lt, input logic [4:0] ls);
    cyc_t c;
    logic b;
    int   fb;
    rst_n = r; en = e; load = l; mode = m; load_taps = lt; load_seed = ls;
    c.ov = 0; c.sv = 0; c.pp = 0;
    if (!r) begin
      m_state = 5'b10101; m_taps = 5'b10010; pend.delete(); m_n = 0;
      m_si = 0; m_sq = 0; m_bit = 0; m_mode_prev = 0;
    end else begin
      if (m != m_mode_prev) pend.delete();
      m_mode_prev = m;
      if (l) begin
        m_taps = lt; m_state = ls; pend.delete(); m_n = 0;
      end
`ifdef MSEQ_LOCKUP_RECOVER_EN
      else if (m_state == 0) begin
        m_state = 5'b10101; pend.delete(); m_n = 0;
      end
`endif
      else if (e) begin
        b = m_state[4];
        fb = $countones(m_state & m_taps) % 2;
        m_state = {m_state[3:0], 1'(fb)};
        m_bit = b;
        c.ov = 1;
        bq.push_back(b);
        m_n++;
        if (m_n == 31) begin
          c.pp = 1; m_n = 0;
        end
        if (m) begin
          pend.push_back(b);
          if (pend.size() == 2) begin
            m_si = amp_of(pend[0]); m_sq = amp_of(pend[1]);
            pend.delete();
            c.sv = 1;
            symq.push_back({m_si, m_sq});
          end
        end
      end
    end
    c.lk = (m_state == 0);
    c.ob = m_bit; c.si = m_si; c.sq = m_sq;
    cq.push_back(c);
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes one control record per cycle, data records on strobes.
  always @(negedge clk) begin
    cyc_t c;
    if (cq.size() == 0) begin
      chk("cycle_queue_underflow", 1, 0);
    end else begin
      c = cq.pop_front();
      chk("out_valid", out_valid, c.ov);
      chk("sym_valid", sym_valid, c.sv);
      chk("period_pulse", period_pulse, c.pp);
      chk("lockup", lockup, c.lk);
      chk("out_bit_hold", out_bit, c.ob);
      chk("sym_i_hold", sym_i, c.si);
      chk("sym_q_hold", sym_q, c.sq);
      if (out_valid) begin
        if (bq.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("out_bit", out_bit, bq.pop_front());
      end
      if (sym_valid) begin
        if (symq.size() == 0) chk("unexpected_symbol", 1, 0);
        else chk("symbol_iq", {sym_i, sym_q}, symq.pop_front());
      end
    end
  end

  initial begin
    // Reset, then serial mode over two full periods.
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    repeat (70) cyc(1, 1, 0, 0, 0, 0);
    // QPSK from reset: first symbol (-100, +100).
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    repeat (20) cyc(1, 1, 0, 1, 0, 0);
    // Load together with en, mid-pair.
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 5'b10010, 5'b00001);
    repeat (10) cyc(1, 1, 0, 1, 0, 0);
    // en toggling in QPSK mode.
    cyc(1, 1, 1, 1, 5'b10010, 5'b10101);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    repeat (6) cyc(1, 1, 0, 1, 0, 0);
    // Reset after an I bit.
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    repeat (6) cyc(1, 1, 0, 1, 0, 0);
    // Mode change mid-pair, then all-zero seed.
    cyc(1, 1, 0, 1, 0, 0);
    repeat (4) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 5'b10010, 5'b00000);
    repeat (8) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 5'b10010, 5'b10101);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic r, e, l, m;
      r = ($urandom_range(0, 79) != 0);
      e = ($urandom_range(0, 99) < 70);
      l = ($urandom_range(0, 39) == 0);
      m = ($urandom_range(0, 19) == 0) ? ~mode : mode;
      cyc(r, e, l, m, 5'($urandom), 5'($urandom));
    end
    @(negedge clk);
    #1;
    chk("bits_left", bq.size(), 0);
    chk("symbols_left", symq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
